axist_patchkr_gen: RTL and testbench



---
 rtl/axist_patchkr_pkg.sv | 23 ++
 rtl/axist_patgen_lanes.sv | 52 +++++
 rtl/axist_patchkr_gen.sv | 206 ++++++++++++++++++++
 tb/tb_axist_patchkr_gen.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axist_patchkr_pkg.sv
// Shared types and helpers for the AXI-ST pattern checker
// and its expected-word generator.
package axist_patchkr_pkg;

  localparam logic [1:0] MODE_CNT  = 2'd0;
  localparam logic [1:0] MODE_LFSR = 2'd1;
  localparam logic [1:0] MODE_FIX  = 2'd2;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Right-shifting Galois form: feedback taps applied on lsb out
  function automatic logic [31:0] lfsr32_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/axist_patgen_lanes.sv
// Expected-word generator: NUM_LANES consecutive words per cycle,
// loadable with a seed and advanced by 0..NUM_LANES words per cycle.
module axist_patgen_lanes
  import axist_patchkr_pkg::*;
#(
  parameter  int NUM_LANES = 2,
  localparam int NW        = $clog2(NUM_LANES + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_load,
  input  logic [1:0]                 i_mode,
  input  logic [31:0]                i_seed,
  input  logic                       i_adv,
  input  logic [NW-1:0]              i_adv_n,
  output logic [NUM_LANES-1:0][31:0] o_exp
);

  logic [1:0]              r_mode;
  logic [31:0]             r_base;
  logic [NUM_LANES:0][31:0] w_seq;

  always_comb begin
    logic [31:0] v;
    w_seq = '0;
    v     = r_base;
    for (int j = 0; j <= NUM_LANES; j++) begin
      w_seq[j] = v;
      case (r_mode)
        MODE_LFSR: v = lfsr32_step(v);
        MODE_FIX:  v = v;
        default:   v = v + 32'd1;
      endcase
    end
  end

  assign o_exp = w_seq[NUM_LANES-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= MODE_CNT;
      r_base <= '0;
    end else if (i_load) begin
      r_mode <= (i_mode == 2'd3) ? MODE_CNT : i_mode;
      r_base <= (i_mode == MODE_LFSR && i_seed == 32'd0) ?
                32'd1 : i_seed;
    end else if (i_adv) begin
      r_base <= w_seq[i_adv_n];
    end
  end

endmodule

// File: rtl/axist_patchkr_gen.sv
// AXI-ST receive pattern checker: compacts kept lanes into a word
// stream, compares against locally generated words, reports status.
module axist_patchkr_gen
  import axist_patchkr_pkg::*;
#(
  parameter int LANE_W    = 256,
  parameter int NUM_LANES = 2,
  parameter int CNT_W     = 16,
  parameter int ERR_W     = 16,
  parameter int TO_W      = 16
) (
  input  logic                          rdclk,
  input  logic                          rst_n,
  input  logic                          chk_start,
  input  logic [1:0]                    chk_mode,
  input  logic [31:0]                   seed,
  input  logic [CNT_W-1:0]              exp_count,
  input  logic [TO_W-1:0]               timeout_limit,
  input  logic                          axist_tvalid,
  input  logic [NUM_LANES*LANE_W-1:0]   axist_tdata,
  input  logic [NUM_LANES-1:0]          axist_tkeep,
  output logic                          axist_tready,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [ERR_W-1:0]              err_count,
  output logic [CNT_W-1:0]              word_count,
  output logic [CNT_W-1:0]              first_err_idx,
  output logic [LANE_W-1:0]             first_err_data,
  output logic                          overrun,
  output logic                          timeout
);

  localparam int NW  = $clog2(NUM_LANES + 1);
  localparam int REP = LANE_W / 32;

  state_t r_state, w_next;

  logic [CNT_W-1:0]  r_exp_cnt, r_acc, r_words, r_ferr_idx;
  logic [TO_W-1:0]   r_idle;
  logic [ERR_W-1:0]  r_err;
  logic [LANE_W-1:0] r_ferr_data;
  logic              r_overrun, r_timeout;

  logic [NUM_LANES-1:0]             r_s_vld;
  logic [NUM_LANES-1:0][LANE_W-1:0] r_s_data;
  logic [NUM_LANES-1:0][31:0]       r_s_exp;
  logic [CNT_W-1:0]                 r_s_base;

  logic                             w_full, w_to_hit, w_to_fire, w_ready;
  logic [NUM_LANES-1:0]             w_acc, w_cvld;
  logic [NUM_LANES-1:0][LANE_W-1:0] w_cdata;
  logic [NUM_LANES-1:0][31:0]       w_exp;
  logic [CNT_W-1:0]                 w_rem;
  logic [NW-1:0]                    w_take, w_nerr, w_nvld;
  logic                             w_over, w_mis_any;
  logic [CNT_W-1:0]                 w_fidx;
  logic [LANE_W-1:0]                w_fdata;
  logic [ERR_W:0]                   w_err_sum;

  assign w_full   = (r_acc == r_exp_cnt);
  assign w_to_hit = (timeout_limit != '0) && (r_idle == timeout_limit);
  assign w_ready  = (r_state == ST_RUN) && !w_full && !w_to_hit;
  assign w_acc    = axist_tkeep & {NUM_LANES{axist_tvalid & w_ready}};
  assign w_rem    = r_exp_cnt - r_acc;
  assign w_to_fire = (r_state == ST_RUN) && !chk_start &&
                     !w_full && w_to_hit;

  // Lane i lands in slot = number of accepted lanes below it
  always_comb begin
    int rank;
    w_cdata = '0;
    w_cvld  = '0;
    w_take  = '0;
    w_over  = 1'b0;
    rank    = 0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (w_acc[i]) begin
        if (rank < int'(w_rem)) begin
          for (int s = 0; s < NUM_LANES; s++) begin
            if (s == rank) begin
              w_cdata[s] = axist_tdata[i*LANE_W +: LANE_W];
              w_cvld[s]  = 1'b1;
            end
          end
          w_take = w_take + 1'b1;
        end else begin
          w_over = 1'b1;
        end
        rank++;
      end
    end
  end

  axist_patgen_lanes #(
    .NUM_LANES (NUM_LANES)
  ) u_gen (
    .clk     (rdclk),
    .rst_n   (rst_n),
    .i_load  (chk_start),
    .i_mode  (chk_mode),
    .i_seed  (seed),
    .i_adv   (w_take != '0),
    .i_adv_n (w_take),
    .o_exp   (w_exp)
  );

  // Descending scan so the lowest mismatching slot wins
  always_comb begin
    w_nerr    = '0;
    w_nvld    = '0;
    w_mis_any = 1'b0;
    w_fidx    = '0;
    w_fdata   = '0;
    for (int j = NUM_LANES - 1; j >= 0; j--) begin
      if (r_s_vld[j]) begin
        w_nvld = w_nvld + 1'b1;
        if (r_s_data[j] != {REP{r_s_exp[j]}}) begin
          w_nerr    = w_nerr + 1'b1;
          w_mis_any = 1'b1;
          w_fidx    = r_s_base + CNT_W'(j);
          w_fdata   = r_s_data[j];
        end
      end
    end
  end

  assign w_err_sum = {1'b0, r_err} + (ERR_W+1)'(w_nerr);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (chk_start) w_next = ST_RUN;
      ST_RUN: begin
        if (chk_start)             w_next = ST_RUN;
        else if (w_full || w_to_hit) w_next = ST_DRAIN;
      end
      ST_DRAIN: w_next = chk_start ? ST_RUN : ST_DONE;
      ST_DONE:  if (chk_start) w_next = ST_RUN;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      r_exp_cnt   <= '0;
      r_acc       <= '0;
      r_idle      <= '0;
      r_err       <= '0;
      r_words     <= '0;
      r_ferr_idx  <= '0;
      r_ferr_data <= '0;
      r_overrun   <= 1'b0;
      r_timeout   <= 1'b0;
      r_s_vld     <= '0;
      r_s_data    <= '0;
      r_s_exp     <= '0;
      r_s_base    <= '0;
    end else if (chk_start) begin
      r_exp_cnt   <= exp_count;
      r_acc       <= '0;
      r_idle      <= '0;
      r_err       <= '0;
      r_words     <= '0;
      r_ferr_idx  <= '0;
      r_ferr_data <= '0;
      r_overrun   <= 1'b0;
      r_timeout   <= 1'b0;
      r_s_vld     <= '0;
    end else begin
      r_s_vld  <= w_cvld;
      r_s_data <= w_cdata;
      r_s_exp  <= w_exp;
      r_s_base <= r_acc;
      r_acc    <= r_acc + CNT_W'(w_take);
      if (w_over)    r_overrun <= 1'b1;
      if (w_to_fire) r_timeout <= 1'b1;
      if (r_state == ST_RUN && !w_full)
        r_idle <= (|w_acc) ? '0 : r_idle + 1'b1;
      r_words <= r_words + CNT_W'(w_nvld);
      r_err   <= w_err_sum[ERR_W] ? '1 : w_err_sum[ERR_W-1:0];
      if (w_mis_any && r_err == '0) begin
        r_ferr_idx  <= w_fidx;
        r_ferr_data <= w_fdata;
      end
    end
  end

  assign axist_tready   = w_ready;
  assign busy           = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done           = (r_state == ST_DONE);
  assign pass           = done && (r_err == '0) && !r_overrun &&
                          !r_timeout && (r_words == r_exp_cnt);
  assign err_count      = r_err;
  assign word_count     = r_words;
  assign first_err_idx  = r_ferr_idx;
  assign first_err_data = r_ferr_data;
  assign overrun        = r_overrun;
  assign timeout        = r_timeout;

endmodule

// File: tb/tb_axist_patchkr_gen.sv
// Directed bench for axist_patchkr_gen with the default
// 2 x 256-bit lane configuration.
module tb_axist_patchkr_gen;

  logic         rdclk = 1'b0;
  logic         rst_n;
  logic         chk_start;
  logic [1:0]   chk_mode;
  logic [31:0]  seed;
  logic [15:0]  exp_count;
  logic [15:0]  timeout_limit;
  logic         axist_tvalid;
  logic [511:0] axist_tdata;
  logic [1:0]   axist_tkeep;
  logic         axist_tready;
  logic         busy, done, pass;
  logic [15:0]  err_count, word_count, first_err_idx;
  logic [255:0] first_err_data;
  logic         overrun, timeout;

  int nvec = 0;
  int nmis = 0;

  axist_patchkr_gen dut (
    .rdclk          (rdclk),
    .rst_n          (rst_n),
    .chk_start      (chk_start),
    .chk_mode       (chk_mode),
    .seed           (seed),
    .exp_count      (exp_count),
    .timeout_limit  (timeout_limit),
    .axist_tvalid   (axist_tvalid),
    .axist_tdata    (axist_tdata),
    .axist_tkeep    (axist_tkeep),
    .axist_tready   (axist_tready),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .word_count     (word_count),
    .first_err_idx  (first_err_idx),
    .first_err_data (first_err_data),
    .overrun        (overrun),
    .timeout        (timeout)
  );

  always #5 rdclk = ~rdclk;

  function automatic logic [255:0] rep(input logic [31:0] w);
    return {8{w}};
  endfunction

  task automatic tick();
    @(posedge rdclk);
    #1;
  endtask

  task automatic start(input logic [1:0] m, input logic [31:0] s,
                       input logic [15:0] n, input logic [15:0] lim);
    chk_mode      = m;
    seed          = s;
    exp_count     = n;
    timeout_limit = lim;
    chk_start     = 1'b1;
    tick();
    chk_start     = 1'b0;
  endtask

  task automatic beat(input logic [1:0] k,
                      input logic [255:0] d0, input logic [255:0] d1);
    int n;
    axist_tdata  = {d1, d0};
    axist_tkeep  = k;
    axist_tvalid = 1'b1;
    n = 0;
    while (!axist_tready && n < 20) begin
      tick();
      n++;
    end
    nvec++;
    if (!axist_tready) begin
      nmis++;
      $display("FAIL beat_accept tready=%b want 1", axist_tready);
    end else begin
      tick();
    end
    axist_tvalid = 1'b0;
    axist_tkeep  = 2'b00;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    nvec++;
    if (!done) begin
      nmis++;
      $display("FAIL wait_done done=%b want 1", done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    nvec++;
    if ({busy, done, pass, overrun, timeout, axist_tready} !== 6'b0) begin
      nmis++;
      $display("FAIL rst_flags got %b want 000000",
               {busy, done, pass, overrun, timeout, axist_tready});
    end
    nvec++;
    if ({err_count, word_count, first_err_idx} !== 48'h0) begin
      nmis++;
      $display("FAIL rst_counts got %h want 0",
               {err_count, word_count, first_err_idx});
    end
    nvec++;
    if (first_err_data !== 256'h0) begin
      nmis++;
      $display("FAIL rst_ferr_data got %h want 0", first_err_data);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_counter();
    start(2'd0, 32'h100, 16'd8, 16'd0);
    beat(2'b11, rep(32'h100), rep(32'h101));
    beat(2'b11, rep(32'h102), rep(32'h103));
    beat(2'b11, rep(32'h104), rep(32'h105));
    beat(2'b11, rep(32'h106), rep(32'h107));
    wait_done();
    nvec++;
    if (pass !== 1'b1 || err_count !== 16'd0) begin
      nmis++;
      $display("FAIL cnt_pass pass=%b err=%0d want 1/0", pass, err_count);
    end
    nvec++;
    if (word_count !== 16'd8) begin
      nmis++;
      $display("FAIL cnt_words got %0d want 8", word_count);
    end
  endtask

  task automatic test_lfsr();
    start(2'd1, 32'h0, 16'd5, 16'd0);
    beat(2'b01, rep(32'h0000_0001), rep(32'hDEAD_BEEF));
    beat(2'b10, rep(32'hDEAD_BEEF), rep(32'h8020_0003));
    beat(2'b11, rep(32'hC030_0002), rep(32'h6018_0001));
    beat(2'b01, rep(32'hB02C_0003), rep(32'hDEAD_BEEF));
    wait_done();
    nvec++;
    if (pass !== 1'b1 || err_count !== 16'd0 || word_count !== 16'd5) begin
      nmis++;
      $display("FAIL lfsr_pass pass=%b err=%0d words=%0d want 1/0/5",
               pass, err_count, word_count);
    end
  endtask

  task automatic test_errors();
    logic [255:0] bad3, bad4;
    bad3 = rep(32'h1003) ^ 256'd1;
    bad4 = rep(32'h1004) ^ 256'd1;
    start(2'd0, 32'h1000, 16'd6, 16'd0);
    beat(2'b11, rep(32'h1000), rep(32'h1001));
    beat(2'b11, rep(32'h1002), bad3);
    beat(2'b11, bad4, rep(32'h1005));
    wait_done();
    nvec++;
    if (err_count !== 16'd2) begin
      nmis++;
      $display("FAIL err_count got %0d want 2", err_count);
    end
    nvec++;
    if (first_err_idx !== 16'd3) begin
      nmis++;
      $display("FAIL err_idx got %0d want 3", first_err_idx);
    end
    nvec++;
    if (first_err_data !== bad3) begin
      nmis++;
      $display("FAIL err_data got %h want %h", first_err_data, bad3);
    end
    nvec++;
    if (pass !== 1'b0 || word_count !== 16'd6) begin
      nmis++;
      $display("FAIL err_pass pass=%b words=%0d want 0/6",
               pass, word_count);
    end
  endtask

  task automatic test_overrun();
    start(2'd0, 32'h20, 16'd3, 16'd0);
    beat(2'b11, rep(32'h20), rep(32'h21));
    beat(2'b11, rep(32'h22), rep(32'h23));
    wait_done();
    nvec++;
    if (overrun !== 1'b1 || word_count !== 16'd3) begin
      nmis++;
      $display("FAIL ovr overrun=%b words=%0d want 1/3",
               overrun, word_count);
    end
    nvec++;
    if (pass !== 1'b0 || err_count !== 16'd0) begin
      nmis++;
      $display("FAIL ovr_pass pass=%b err=%0d want 0/0", pass, err_count);
    end
  endtask

  task automatic test_timeout();
    start(2'd2, 32'h5A5A_0F0F, 16'd4, 16'd10);
    beat(2'b11, rep(32'h5A5A_0F0F), rep(32'h5A5A_0F0F));
    repeat (9) tick();
    nvec++;
    if (busy !== 1'b1 || timeout !== 1'b0) begin
      nmis++;
      $display("FAIL to_early busy=%b timeout=%b want 1/0", busy, timeout);
    end
    wait_done();
    nvec++;
    if (timeout !== 1'b1 || pass !== 1'b0 || word_count !== 16'd2) begin
      nmis++;
      $display("FAIL to_end timeout=%b pass=%b words=%0d want 1/0/2",
               timeout, pass, word_count);
    end
  endtask

  task automatic test_zero();
    start(2'd0, 32'h0, 16'd0, 16'd0);
    wait_done();
    nvec++;
    if (pass !== 1'b1 || word_count !== 16'd0) begin
      nmis++;
      $display("FAIL zero pass=%b words=%0d want 1/0", pass, word_count);
    end
  endtask

  task automatic test_abort();
    start(2'd0, 32'h50, 16'd8, 16'd0);
    beat(2'b11, rep(32'h50), rep(32'hFFFF));
    start(2'd0, 32'h200, 16'd4, 16'd0);
    nvec++;
    if (word_count !== 16'd0 || err_count !== 16'd0 || busy !== 1'b1) begin
      nmis++;
      $display("FAIL abort_clr words=%0d err=%0d busy=%b want 0/0/1",
               word_count, err_count, busy);
    end
    beat(2'b11, rep(32'h200), rep(32'h201));
    beat(2'b11, rep(32'h202), rep(32'h203));
    wait_done();
    nvec++;
    if (pass !== 1'b1 || word_count !== 16'd4) begin
      nmis++;
      $display("FAIL abort_pass pass=%b words=%0d want 1/4",
               pass, word_count);
    end
  endtask

  task automatic test_reset_drain();
    start(2'd0, 32'h0, 16'd2, 16'd0);
    beat(2'b11, rep(32'h0), rep(32'h1));
    tick();
    nvec++;
    if (busy !== 1'b1 || done !== 1'b0 || word_count !== 16'd2) begin
      nmis++;
      $display("FAIL drain busy=%b done=%b words=%0d want 1/0/2",
               busy, done, word_count);
    end
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({busy, done, pass, axist_tready} !== 4'b0 ||
        word_count !== 16'd0) begin
      nmis++;
      $display("FAIL rst_drain flags=%b words=%0d want 0000/0",
               {busy, done, pass, axist_tready}, word_count);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n         = 1'b0;
    chk_start     = 1'b0;
    chk_mode      = 2'd0;
    seed          = 32'h0;
    exp_count     = 16'd0;
    timeout_limit = 16'd0;
    axist_tvalid  = 1'b0;
    axist_tdata   = '0;
    axist_tkeep   = 2'b00;
    #1;
    test_reset();
    test_counter();
    test_lfsr();
    test_errors();
    test_overrun();
    test_timeout();
    test_zero();
    test_abort();
    test_reset_drain();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
